// File: rtl/sm4_cbc_ctrl.sv
// CBC-mode sequencer around a single-block SM4 engine: loads a session, chains
// each block through the core via a start/done handshake, and streams results out.
module sm4_cbc_ctrl #(
  parameter int TO_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic             dir_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_start,
  output logic             core_action,
  output logic [127:0]     core_text,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  // Last WAIT count before giving up, so timeout lands on the 2^TO_W-1'th WAIT cycle.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state;
  state_t          state_nxt;
  logic [127:0]    chain;
  logic [127:0]    hold;
  logic [TO_W-1:0] to_cnt;
  logic            done_ok;
  logic            timeout;

  // to_cnt is zero only in the first WAIT cycle, where a done is not trusted.
  assign done_ok = core_done && (to_cnt != '0);
  assign timeout = !done_ok && (to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (init) state_nxt = S_READY;
      end
      S_READY: begin
        in_ready = 1'b1;
        if (!init && in_valid) state_nxt = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (done_ok) begin
          state_nxt = S_OUT;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the wide datapath registers are reset too, because a reset must
  // leave out_data, core_text and core_key at zero, not at a stale block.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key    <= '0;
      core_action <= 1'b0;
      core_text   <= '0;
      chain       <= '0;
      hold        <= '0;
      out_data    <= '0;
      to_cnt      <= '0;
      err         <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (init) begin
            core_key    <= key_in;
            core_action <= dir_in;
            chain       <= iv_in;
            err         <= 1'b0;
            blk_cnt     <= '0;
          end else if (state == S_READY && in_valid) begin
            // Encrypt whitens the plaintext; decrypt keeps the ciphertext for the next chain.
            core_text <= core_action ? in_data : (in_data ^ chain);
            hold      <= in_data;
          end
        end
        S_START: begin
          to_cnt <= '0;
        end
        S_WAIT: begin
          if (done_ok) begin
            out_data <= core_action ? (core_out ^ chain) : core_out;
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            // Chain advances only once the sink has taken the block.
            chain   <= core_action ? hold : out_data;
            blk_cnt <= blk_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sm4_cbc_ctrl.md
Name: sm4_cbc_ctrl

Overview:
CBC-mode sequencer that drives one sm4_logic core as the initiator of its start/done handshake. It accepts a session (key, IV, direction), then streams 128-bit blocks through the core, chaining each block per CBC. It sits between a valid/ready block source/sink and the single-block SM4 engine.

Parameters:
TO_W, 8, width of the WAIT-state timeout counter; timeout fires after 2^TO_W-1 cycles without core done.
CNT_W, 16, width of the processed-block counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
init  input  1  session-load pulse; samples key_in, iv_in, dir_in.
key_in  input  128  session key.
iv_in  input  128  initial chaining value.
dir_in  input  1  0 = encrypt, 1 = decrypt.
in_valid  input  1  input block valid.
in_ready  output  1  controller can accept a block.
in_data  input  128  plaintext (encrypt) or ciphertext (decrypt).
out_valid  output  1  result block valid.
out_ready  input  1  sink accepts the result.
out_data  output  128  ciphertext (encrypt) or plaintext (decrypt).
core_start  output  1  one-cycle start pulse to sm4_logic.
core_action  output  1  to sm4_logic action; equals session dir.
core_text  output  128  to sm4_logic text_in.
core_key  output  128  to sm4_logic key.
core_out  input  128  from sm4_logic text_out.
core_done  input  1  from sm4_logic done.
busy  output  1  high in START, WAIT and OUT.
err  output  1  sticky timeout flag; cleared by init or rst.
blk_cnt  output  CNT_W  blocks completed since last init; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. in_ready, out_valid, core_start, busy and err are 0. blk_cnt, out_data, core_text, core_key, the chain register and core_action are 0.
- States: IDLE, READY, START, WAIT, OUT.
- IDLE: in_ready=0. On init, latch key, chain=iv_in, dir; clear err and blk_cnt; go to READY.
- READY: in_ready=1. init has priority over in_valid in the same cycle: the session reloads, no block is taken, and the state stays READY. Otherwise, on in_valid, latch the block. Encrypt: core_text = in_data XOR chain. Decrypt: core_text = in_data, and the ciphertext is kept in a hold register. Go to START.
- START: core_start=1 for exactly this cycle; go to WAIT. Clear the timeout counter.
- WAIT: core_done is ignored in the first WAIT cycle. From the second cycle on, the first cycle with core_done=1 captures the result. Encrypt: out_data = core_out and next chain = core_out. Decrypt: out_data = core_out XOR chain and next chain = hold. Then go to OUT.
- WAIT timeout: when the counter reaches 2^TO_W-1 with no done, set err=1 and go to IDLE. The chain register and blk_cnt are left unchanged, and no output is produced.
- OUT: out_valid=1 and out_data stays stable until accepted. When out_ready=1, commit the chain, increment blk_cnt, and go to READY. A new input is not accepted in the same cycle.
- core_key and core_action are stable from init until the next init. core_text is stable from START through WAIT.
- init is ignored in START, WAIT and OUT.
- Latency is in_valid accept to out_valid = 2 + (core done delay) cycles. Throughput is one block per core run; there is no overlap.
- rst mid-operation aborts immediately with no output. Any later core_done is ignored because the state is not WAIT.

Test Plan:
- Encrypt ECB equivalence: init with key=0123456789abcdeffedcba9876543210, iv=0, dir=0; send in_data=0123456789abcdeffedcba9876543210 -> out_data=681edf34d206965e86b3e94f536e4246, blk_cnt=1.
- Encrypt CBC chain: same session, second block 693d9a535bad5bb1786f53d7253a7056 -> core_text=0123456789abcdeffedcba9876543210, out_data=681edf34d206965e86b3e94f536e4246, blk_cnt=2.
- Decrypt chain: init with the same key, iv=0, dir=1; send 681edf34d206965e86b3e94f536e4246 twice -> outputs 0123456789abcdeffedcba9876543210 then 693d9a535bad5bb1786f53d7253a7056.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, out_data stable, in_ready=0, exactly one core_start per block.
- Timeout: core model never asserts done -> err=1 after 255 WAIT cycles, state IDLE, in_ready=0; init clears err.
- Priority and reset: init together with in_valid in READY -> session reloads and no core_start; rst asserted in WAIT, then a late core_done -> no out_valid, all outputs at reset values.
